// File: rtl/spi_master_seq_if.sv
// Bundle between the local controller, spi_master_seq and the SPI slave pins.
// The slave modport is the master sequencer's view; the master modport is the controller/pad view.
interface spi_master_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_read;
  logic [7:0] req_addr;
  logic [2:0] req_len;
  logic [7:0] wdata;
  logic       wdata_valid;
  logic       wdata_ready;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic       SCK;
  logic       CSB;
  logic       SDI;
  logic       SDO;

  modport slave (
    input  req_valid, req_write, req_read, req_addr, req_len, wdata, wdata_valid, SDO,
    output req_ready, wdata_ready, rdata, rdata_valid, busy, done, err, SCK, CSB, SDI
  );

  modport master (
    output req_valid, req_write, req_read, req_addr, req_len, wdata, wdata_valid, SDO,
    input  req_ready, wdata_ready, rdata, rdata_valid, busy, done, err, SCK, CSB, SDI
  );
endinterface

// File: rtl/spi_master_seq.sv
// SPI master sequencing cmd/addr/1-8 data byte frames, MSB first; optional wdata stall abort under SPI_MASTER_TIMEOUT_EN.
// Latency: CSB low 2*CLKDIV*nbits + CLKDIV cycles plus any wdata stall; all outputs registered.
// Backpressure: req_ready only in IDLE; SCK is frozen low while a write byte waits on wdata_valid.
module spi_master_seq #(
  parameter int CLKDIV  = 2,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  spi_master_seq_if.slave  bus
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] C_PRE  = (CLKDIV > 1) ? CW'(CLKDIV - 2) : '0;
`ifdef SPI_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_BIT, S_WDATA, S_HOLD, S_GAP} state_t;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          hi;
    logic [2:0]    bitn;
    logic [3:0]    byten;
    logic [3:0]    nbytes;
    logic          wr;
    logic          rd;
    logic [7:0]    addr;
    logic [6:0]    tx;
    logic [6:0]    rx;
    logic          sck;
    logic          csb;
    logic          sdi;
    logic          req_ready;
    logic          wdata_ready;
    logic [7:0]    rdata;
    logic          rdata_valid;
    logic          busy;
    logic          done;
`ifdef SPI_MASTER_TIMEOUT_EN
    logic [TW-1:0] tocnt;
    logic          err;
`endif
  } regs_t;

  state_t r_state;
  state_t w_state_nxt;
  regs_t  r_q;
  regs_t  w_d;
  logic   w_cnt_end;
  logic   w_last_bit;
  logic   w_last_byte;
  logic   w_next_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_q.csb <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_d;
    end
  end

  assign w_cnt_end   = (r_q.cnt == C_LAST);
  assign w_last_bit  = (r_q.bitn == 3'd7);
  assign w_last_byte = (r_q.byten == (r_q.nbytes - 4'd1));
  // The byte that follows the current one carries controller write data.
  assign w_next_wr   = r_q.wr && !w_last_byte && (r_q.byten != 4'd0);

  always_comb begin
    w_state_nxt     = r_state;
    w_d             = r_q;
    w_d.rdata_valid = 1'b0;
    w_d.done        = 1'b0;
`ifdef SPI_MASTER_TIMEOUT_EN
    w_d.err         = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_d.req_ready = 1'b1;
        if (bus.req_valid && r_q.req_ready) begin
          w_d.wr        = bus.req_write;
          w_d.rd        = bus.req_read;
          w_d.addr      = bus.req_addr;
          w_d.nbytes    = (bus.req_len == 3'd0) ? 4'd10 : ({1'b0, bus.req_len} + 4'd2);
          w_d.sdi       = bus.req_write;
          w_d.tx        = {bus.req_read, bus.req_len, 3'b000};
          w_d.csb       = 1'b0;
          w_d.sck       = 1'b0;
          w_d.busy      = 1'b1;
          w_d.req_ready = 1'b0;
          w_d.byten     = 4'd0;
          w_d.bitn      = 3'd0;
          w_d.hi        = 1'b0;
          w_d.cnt       = '0;
          w_state_nxt   = S_BIT;
        end
      end

      S_BIT: begin
        w_d.cnt = r_q.cnt + CW'(1);
        if (!r_q.hi) begin
          if (w_cnt_end) begin
            w_d.cnt = '0;
            w_d.hi  = 1'b1;
            w_d.sck = 1'b1;
            if (CLKDIV == 1 && w_last_bit && w_next_wr) w_d.wdata_ready = 1'b1;
          end
        end else begin
          // Open wdata_ready for the final high cycle so an eager producer costs no extra cycle.
          if (CLKDIV > 1 && r_q.cnt == C_PRE && w_last_bit && w_next_wr) w_d.wdata_ready = 1'b1;
          if (w_cnt_end) begin
            w_d.cnt = '0;
            w_d.hi  = 1'b0;
            w_d.sck = 1'b0;
            w_d.rx  = {r_q.rx[5:0], bus.SDO};
            if (!w_last_bit) begin
              w_d.bitn = r_q.bitn + 3'd1;
              w_d.sdi  = r_q.tx[6];
              w_d.tx   = {r_q.tx[5:0], 1'b0};
            end else begin
              w_d.bitn = 3'd0;
              if (r_q.rd && r_q.byten >= 4'd2) begin
                w_d.rdata       = {r_q.rx, bus.SDO};
                w_d.rdata_valid = 1'b1;
              end
              if (w_last_byte) begin
                w_state_nxt = S_HOLD;
              end else begin
                w_d.byten = r_q.byten + 4'd1;
                if (w_next_wr) begin
                  if (bus.wdata_valid && r_q.wdata_ready) begin
                    w_d.sdi         = bus.wdata[7];
                    w_d.tx          = bus.wdata[6:0];
                    w_d.wdata_ready = 1'b0;
                  end else begin
                    w_state_nxt = S_WDATA;
`ifdef SPI_MASTER_TIMEOUT_EN
                    w_d.tocnt   = '0;
`endif
                  end
                end else if (r_q.byten == 4'd0) begin
                  w_d.sdi = r_q.addr[7];
                  w_d.tx  = r_q.addr[6:0];
                end else begin
                  w_d.sdi = 1'b0;
                  w_d.tx  = '0;
                end
              end
            end
          end
        end
      end

      S_WDATA: begin
        w_d.sck         = 1'b0;
        w_d.wdata_ready = 1'b1;
        if (bus.wdata_valid) begin
          w_d.sdi         = bus.wdata[7];
          w_d.tx          = bus.wdata[6:0];
          w_d.wdata_ready = 1'b0;
          w_d.hi          = 1'b0;
          w_d.cnt         = '0;
          w_state_nxt     = S_BIT;
        end
`ifdef SPI_MASTER_TIMEOUT_EN
        else if (r_q.tocnt == C_TO_LAST) begin
          w_d.csb         = 1'b1;
          w_d.wdata_ready = 1'b0;
          w_d.err         = 1'b1;
          w_d.cnt         = '0;
          w_state_nxt     = S_GAP;
        end else begin
          w_d.tocnt = r_q.tocnt + TW'(1);
        end
`endif
      end

      S_HOLD: begin
        w_d.sck = 1'b0;
        w_d.cnt = r_q.cnt + CW'(1);
        if (w_cnt_end) begin
          w_d.cnt     = '0;
          w_d.csb     = 1'b1;
          w_d.done    = 1'b1;
          w_state_nxt = S_GAP;
        end
      end

      S_GAP: begin
        w_d.cnt = r_q.cnt + CW'(1);
        if (w_cnt_end) begin
          w_d.cnt       = '0;
          w_d.busy      = 1'b0;
          w_d.req_ready = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready   = r_q.req_ready;
  assign bus.wdata_ready = r_q.wdata_ready;
  assign bus.rdata       = r_q.rdata;
  assign bus.rdata_valid = r_q.rdata_valid;
  assign bus.busy        = r_q.busy;
  assign bus.done        = r_q.done;
  assign bus.SCK         = r_q.sck;
  assign bus.CSB         = r_q.csb;
  assign bus.SDI         = r_q.sdi;
`ifdef SPI_MASTER_TIMEOUT_EN
  assign bus.err         = r_q.err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign bus.err         = 1'b0;
`endif

endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
- On-chip SPI master that sequences complete transactions into the team's SPI register slave (command byte, address byte, 1-8 data bytes), MSB first.
- A simple request handshake and per-byte write/read data streams let a local controller read or write slave registers without handling SCK/CSB timing.
- Sits between the system-side controller and the SCK/CSB/SDI/SDO pins of the slave.

Parameters:
- CLKDIV, 2, SCK half-period in clk cycles (>=1).
- TIMEOUT, 255, max wdata stall cycles before abort (used only with SPI_MASTER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  transaction request.
- req_ready  out  1  master idle, accepts a request.
- req_write  in  1  command write bit.
- req_read  in  1  command read bit.
- req_addr  in  8  register address.
- req_len  in  3  data byte count; 1-7 = fixed count, 0 = 8 bytes (slave streaming mode).
- wdata  in  8  write byte.
- wdata_valid  in  1  wdata present.
- wdata_ready  out  1  master consumes wdata this cycle when wdata_valid is high.
- rdata  out  8  byte shifted in from SDO during a data byte.
- rdata_valid  out  1  one-cycle pulse, rdata valid.
- busy  out  1  transaction in progress (CSB low or gap).
- done  out  1  one-cycle pulse when CSB returns high after a normal end.
- err  out  1  one-cycle abort pulse (constant 0 without the macro).
- SCK  out  1  SPI clock, idle low.
- CSB  out  1  chip select, active low.
- SDI  out  1  serial data to slave.
- SDO  in  1  serial data from slave.

Behaviour:
- Reset (synchronous): CSB=1, SCK=0, SDI=0, req_ready=0 during reset and 1 from the first cycle after; wdata_ready=0, rdata=0, rdata_valid=0, busy=0, done=0, err=0. Reset asserted mid-transaction drops to IDLE immediately (CSB=1, SCK=0). The slave resets on CSB high.
- All outputs are registered. D = CLKDIV.
- Command byte = {req_write, req_read, req_len, 3'b000}. Bits shifted: 16 + 8*N, where N = req_len, or 8 if req_len = 0.
- States:
  - IDLE: req_ready=1. Accepts on req_valid&&req_ready, latches all req_* fields, goes to BIT. req_ready drops the next cycle.
  - BIT: low phase of D cycles, then high phase of D cycles.
    - SDI and SCK=0 update on the edge that starts the low phase.
    - SCK=1 on the edge that starts the high phase.
    - SDO is sampled on the edge that ends the high phase (drives SCK low).
  - Byte boundaries: before each data byte when the write bit is latched, go to WDATA instead of starting the low phase.
  - WDATA: SCK=0, wdata_ready=1. On wdata_valid, load the byte, drop wdata_ready, and start its low phase the same edge. Waits indefinitely, holding SCK low, CSB low and SDI unchanged.
  - rdata: rdata_valid pulses the cycle after the 8th SDO sample of each data byte when the read bit is latched; rdata = the 8 sampled bits, MSB first. Sampling is suppressed during command and address bytes.
  - HOLD: after the last bit, SCK=0 for D cycles, then CSB=1 and done=1.
  - GAP: CSB high for D cycles, busy=1, then IDLE.
- Timing: CSB low duration without stalls = 2D*nbits + D. CSB fall to first SCK rise = D.
- A read with no write bit never asserts wdata_ready. Write+read (both bits) is full-duplex: wdata consumed and rdata returned per byte.
- A request with neither bit set still runs the full frame: data SDI = 0, no rdata.
- req_* changes while busy are ignored.

Optional Feature:
- Macro SPI_MASTER_TIMEOUT_EN.
- Defined: a counter runs in WDATA. If the stall reaches TIMEOUT cycles:
  - abort: SCK=0, CSB=1 next cycle;
  - err pulses 1 cycle, no done pulse;
  - then GAP, then IDLE.
- Undefined: no counter, WDATA waits forever, err tied 0.

Test Plan:
- CLKDIV=2, write addr 0x12, len=1, wdata 0xA5 ready immediately -> SDI bits = 0x88,0x12,0xA5; CSB low 98 cycles; one wdata_ready handshake; done pulse once; no rdata_valid.
- Read addr 0x05, len=3, slave model returns 0x3C,0x3D,0x3E -> command 0x58; three rdata_valid pulses with those values in order; wdata_ready never high.
- Write len=0 -> command 0x80; 80 SCK rising edges; 8 wdata handshakes.
- Write len=2, wdata_valid withheld 50 cycles before byte 2 -> SCK low and CSB low throughout the stall; the frame resumes correctly; CSB low duration extended by exactly the stall.
- Reset asserted mid address byte -> next cycle CSB=1, SCK=0, busy=0; req_ready=1 after reset deasserts; a new request completes normally.
- With SPI_MASTER_TIMEOUT_EN, TIMEOUT=16, wdata never valid -> err pulses once, CSB=1, no done; IDLE after GAP.
